muldiv_unit: RTL

- Iterative RV32M multiply/divide execution unit.
- Consumes the M-extension operation code produced by ALU control decode (funct7 = 0000001, funct3 selects the op).
- Returns results to the datapath through a start/busy/done handshake, so the core stalls on M-type instructions.
- Shift-add multiply and restoring divide; 32 iterations per operation.

---
 rtl/muldiv_unit_pkg.sv | 31 +++
 rtl/muldiv_unit_core_iter.sv | 34 +++
 rtl/muldiv_unit.sv | 119 +++++++++++
 3 files changed

// File: rtl/muldiv_unit_pkg.sv
// RV32M multiply/divide op codes, FSM state encoding and operand-signedness helpers.
// Shared by the iterative unit and anything decoding M-extension instructions.
package muldiv_unit_pkg;

   localparam logic [6:0] FUNCT7_MULDIV = 7'b0000001;

   localparam logic [2:0] MD_MUL    = 3'b000;
   localparam logic [2:0] MD_MULH   = 3'b001;
   localparam logic [2:0] MD_MULHSU = 3'b010;
   localparam logic [2:0] MD_MULHU  = 3'b011;
   localparam logic [2:0] MD_DIV    = 3'b100;
   localparam logic [2:0] MD_DIVU   = 3'b101;
   localparam logic [2:0] MD_REM    = 3'b110;
   localparam logic [2:0] MD_REMU   = 3'b111;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      CALC = 2'd1,
      FIX  = 2'd2,
      DONE = 2'd3
   } md_state_e;

   function automatic logic rs1_signed(input logic [2:0] f);
      return (f == MD_MULH) || (f == MD_MULHSU) || (f == MD_DIV) || (f == MD_REM);
   endfunction

   function automatic logic rs2_signed(input logic [2:0] f);
      return (f == MD_MULH) || (f == MD_DIV) || (f == MD_REM);
   endfunction

endpackage

// File: rtl/muldiv_unit_core_iter.sv
// One shift-add multiply step or one restoring-divide step on unsigned magnitudes.
// Purely combinational; the caller registers the outputs once per cycle.
module muldiv_core_iter #(
   parameter int XLEN = 32
) (
   input  logic              is_div,
   input  logic [2*XLEN-1:0] acc,
   input  logic [XLEN:0]     rem,
   input  logic [XLEN-1:0]   opnd,
   output logic [2*XLEN-1:0] acc_next,
   output logic [XLEN:0]     rem_next
);

   logic [XLEN:0] add_sum;
   logic [XLEN:0] shifted;
   logic [XLEN:0] diff;

   // Multiply: acc = {partial product, remaining multiplier bits}.
   // Divide: acc[XLEN-1:0] shifts dividend bits out and quotient bits in.
   always_comb begin
      add_sum  = {1'b0, acc[2*XLEN-1:XLEN]} + (acc[0] ? {1'b0, opnd} : '0);
      shifted  = {rem[XLEN-1:0], acc[XLEN-1]};
      diff     = shifted - {1'b0, opnd};
      acc_next = '0;
      rem_next = rem;
      if (is_div) begin
         acc_next = {acc[2*XLEN-1:XLEN], acc[XLEN-2:0], ~diff[XLEN]};
         rem_next = diff[XLEN] ? shifted : diff;
      end else begin
         acc_next = {add_sum, acc[XLEN-1:1]};
      end
   end

endmodule

// File: rtl/muldiv_unit.sv
// Iterative RV32M multiply/divide: XLEN cycles per op plus accept, 2 cycles for div special cases.
// start is only honoured in IDLE; requests while busy or on the done cycle are dropped, not queued.
module muldiv_unit
   import muldiv_unit_pkg::*;
#(
   parameter int XLEN = 32
) (
   input  logic            clk,
   input  logic            rst_n,
   input  logic            start,
   input  logic [2:0]      funct3,
   input  logic [XLEN-1:0] rs1,
   input  logic [XLEN-1:0] rs2,
   output logic            busy,
   output logic            done,
   output logic [XLEN-1:0] result
);

   localparam int CW = $clog2(XLEN) + 1;
   localparam logic [XLEN-1:0] INT_MIN = {1'b1, {(XLEN-1){1'b0}}};

   md_state_e         state;
   logic [CW-1:0]     cnt;
   logic [2:0]        op;
   logic              neg;
   logic [2*XLEN-1:0] acc;
   logic [2*XLEN-1:0] acc_next;
   logic [XLEN:0]     rem;
   logic [XLEN:0]     rem_next;
   logic [XLEN-1:0]   opnd;

   logic              s1, s2, div0, ovf;
   logic [XLEN-1:0]   mag1, mag2, fix_val, calc_res, quo, rmd;
   logic [2*XLEN-1:0] prod;

   muldiv_core_iter #(.XLEN(XLEN)) u_iter (
      .is_div   (op[2]),
      .acc      (acc),
      .rem      (rem),
      .opnd     (opnd),
      .acc_next (acc_next),
      .rem_next (rem_next)
   );

   always_comb begin
      s1      = rs1[XLEN-1] & rs1_signed(funct3);
      s2      = rs2[XLEN-1] & rs2_signed(funct3);
      mag1    = s1 ? -rs1 : rs1;
      mag2    = s2 ? -rs2 : rs2;
      div0    = (rs2 == '0);
      ovf     = ((funct3 == MD_DIV) || (funct3 == MD_REM)) && (rs1 == INT_MIN) && (rs2 == '1);
      // funct3[1] separates REM/REMU from DIV/DIVU
      fix_val = div0 ? (funct3[1] ? rs1 : '1) : (funct3[1] ? '0 : INT_MIN);

      prod = neg ? -acc_next : acc_next;
      quo  = neg ? -acc_next[XLEN-1:0] : acc_next[XLEN-1:0];
      rmd  = neg ? -rem_next[XLEN-1:0] : rem_next[XLEN-1:0];
      if (!op[2]) calc_res = (op == MD_MUL) ? prod[XLEN-1:0] : prod[2*XLEN-1:XLEN];
      else        calc_res = op[1] ? rmd : quo;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state  <= IDLE;
         cnt    <= '0;
         op     <= '0;
         neg    <= 1'b0;
         acc    <= '0;
         rem    <= '0;
         opnd   <= '0;
         busy   <= 1'b0;
         done   <= 1'b0;
         result <= '0;
      end else begin
         done <= 1'b0;
         case (state)
            IDLE: begin
               if (start) begin
                  op   <= funct3;
                  cnt  <= '0;
                  rem  <= '0;
                  busy <= 1'b1;
                  neg  <= (funct3[2] & funct3[1]) ? s1 : (s1 ^ s2);
                  if (funct3[2] && (div0 || ovf)) begin
                     state <= FIX;
                     acc   <= {{XLEN{1'b0}}, fix_val};
                  end else begin
                     state <= CALC;
                     acc   <= {{XLEN{1'b0}}, funct3[2] ? mag1 : mag2};
                     opnd  <= funct3[2] ? mag2 : mag1;
                  end
               end
            end
            CALC: begin
               acc <= acc_next;
               rem <= rem_next;
               if (cnt == CW'(XLEN-1)) begin
                  state  <= DONE;
                  cnt    <= '0;
                  busy   <= 1'b0;
                  done   <= 1'b1;
                  result <= calc_res;
               end else begin
                  cnt <= cnt + 1'b1;
               end
            end
            FIX: begin
               state  <= DONE;
               busy   <= 1'b0;
               done   <= 1'b1;
               result <= acc[XLEN-1:0];
            end
            DONE:    state <= IDLE;
            default: state <= IDLE;
         endcase
      end
   end

endmodule
